// File: rtl/ram_bist_pkg.sv
// Shared types and the BIST data pattern for the RAM test block.
package ram_bist_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ,
        DRAIN,
        DONE
    } state_t;

    localparam logic [7:0] PAT_XOR = 8'hA5;

    // Byte written by the BIST to lane `lane` of word `addr` (low 8 address bits only).
    function automatic logic [7:0] pattern_byte(input logic [7:0] addr, input logic [7:0] lane);
        return (addr + lane) ^ PAT_XOR;
    endfunction

endpackage

// File: rtl/ram_bist_test_ram.sv
// Inferred single-port RAM: byte-lane write enables, registered read-first output.
module ram_sp_be #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [DATA_W/8-1:0]   be,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [DATA_W-1:0]     wdata,
    output logic [DATA_W-1:0]     rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // Lane-masked write; the array itself is never reset.
    always_ff @(posedge clk) begin
        for (int k = 0; k < DATA_W / 8; k++) begin
            if (we && be[k]) begin
                mem[addr][8*k +: 8] <= wdata[8*k +: 8];
            end
        end
    end

    // Output register samples the pre-write contents, giving read-first behaviour.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/ram_bist_test.sv
// RAM test block: manual switch-driven access plus a fill/read-back BIST sweep.
module ram_bist_test
    import ram_bist_pkg::*;
#(
    parameter int  DATA_W = 32,
    parameter int  ADDR_W = 6,
    localparam int NB     = DATA_W / 8,
    localparam int SEL_W  = (NB > 1) ? $clog2(NB) : 1,
    localparam int ERR_W  = ADDR_W + 1
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Start,
    input  logic              Fault_Inj,
    input  logic [ADDR_W-1:0] Mem_Addr,
    input  logic              Mem_Write,
    input  logic [NB-1:0]     Byte_En,
    input  logic [DATA_W-1:0] W_Data,
    input  logic [SEL_W-1:0]  Select,
    output logic [DATA_W-1:0] Rd_Data,
    output logic [7:0]        LED,
    output logic              Busy,
    output logic              Done,
    output logic              Pass,
    output logic [ERR_W-1:0]  Err_Count
);

    state_t            state, state_nx;
    logic [ADDR_W-1:0] bist_addr;
    logic [ADDR_W-1:0] cmp_addr;
    logic              cmp_vld;
    logic              addr_last;
    logic              start_go;

    logic              ram_we;
    logic [NB-1:0]     ram_be;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;

    function automatic logic [DATA_W-1:0] pattern_word(input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] w;
        w = '0;
        for (int k = 0; k < NB; k++) begin
            w[8*k +: 8] = pattern_byte(8'(a), 8'(k));
        end
        return w;
    endfunction

    assign addr_last = (bist_addr == {ADDR_W{1'b1}});
    assign start_go  = Start && (state == IDLE || state == DONE);

    assign Busy = (state == WRITE) || (state == READ) || (state == DRAIN);
    assign Done = (state == DONE);
    assign Pass = Done && (Err_Count == '0);

    // State register.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state: fill, read back, one extra cycle to compare the last word.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE, DONE: if (Start) state_nx = WRITE;
            WRITE:      if (addr_last) state_nx = READ;
            READ:       if (addr_last) state_nx = DRAIN;
            DRAIN:      state_nx = DONE;
            default:    state_nx = IDLE;
        endcase
    end

    // Sweep address, delayed read address for the compare, and error counter.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            bist_addr <= '0;
            cmp_addr  <= '0;
            cmp_vld   <= 1'b0;
            Err_Count <= '0;
        end else begin
            cmp_vld  <= (state == READ);
            cmp_addr <= bist_addr;
            if (start_go) begin
                bist_addr <= '0;
                Err_Count <= '0;
            end else begin
                if (state == WRITE || state == READ) begin
                    bist_addr <= bist_addr + ADDR_W'(1);
                end
                if (cmp_vld && (Rd_Data != pattern_word(cmp_addr)) && (Err_Count != '1)) begin
                    Err_Count <= Err_Count + ERR_W'(1);
                end
            end
        end
    end

    // RAM port mux: switches own the port only while idle; Start beats a manual write.
    always_comb begin
        ram_addr  = Mem_Addr;
        ram_we    = 1'b0;
        ram_be    = '1;
        ram_wdata = W_Data;
        case (state)
            IDLE, DONE: begin
                ram_we = Mem_Write && !Start && !Rst;
                ram_be = Byte_En;
            end
            WRITE: begin
                ram_addr  = bist_addr;
                ram_we    = !Rst;
                ram_wdata = pattern_word(bist_addr) ^ DATA_W'(Fault_Inj);
            end
            default: begin
                ram_addr = bist_addr;
            end
        endcase
    end

    ram_sp_be #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (Clk),
        .rst   (Rst),
        .we    (ram_we),
        .be    (ram_be),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (Rd_Data)
    );

    // LED shows the selected byte lane; out-of-range selects show zero.
    always_comb begin
        LED = '0;
        for (int k = 0; k < NB; k++) begin
            if (Select == SEL_W'(k)) LED = Rd_Data[8*k +: 8];
        end
    end

endmodule

// File: tb/tb_ram_bist_test.sv
// Bench for ram_bist_test: cycle-level reference model, directed cases and random traffic.
module tb_ram_bist_test;

    localparam int D = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, fault, mem_write;
    logic [5:0]  mem_addr;
    logic [3:0]  byte_en;
    logic [31:0] w_data;
    logic [1:0]  sel;
    logic [31:0] rd_data;
    logic [7:0]  led;
    logic        busy, done, pass;
    logic [6:0]  err_count;

    logic        a_start, a_fault, a_mem_write;
    logic [3:0]  a_mem_addr;
    logic [1:0]  a_byte_en;
    logic [15:0] a_w_data;
    logic [0:0]  a_sel;
    logic [15:0] a_rd;
    logic [7:0]  a_led;
    logic        a_busy, a_done, a_pass;
    logic [4:0]  a_err;

    ram_bist_test dut (
        .Clk(clk), .Rst(rst), .Start(start), .Fault_Inj(fault), .Mem_Addr(mem_addr),
        .Mem_Write(mem_write), .Byte_En(byte_en), .W_Data(w_data), .Select(sel),
        .Rd_Data(rd_data), .LED(led), .Busy(busy), .Done(done), .Pass(pass), .Err_Count(err_count)
    );

    ram_bist_test #(.DATA_W(16), .ADDR_W(4)) dut_alt (
        .Clk(clk), .Rst(rst), .Start(a_start), .Fault_Inj(a_fault), .Mem_Addr(a_mem_addr),
        .Mem_Write(a_mem_write), .Byte_En(a_byte_en), .W_Data(a_w_data), .Select(a_sel),
        .Rd_Data(a_rd), .LED(a_led), .Busy(a_busy), .Done(a_done), .Pass(a_pass), .Err_Count(a_err)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Expected word from the pattern rule: byte k of word a = ((a + k) mod 256) ^ A5.
    function automatic logic [31:0] pat(input int a);
        logic [31:0] w;
        for (int k = 0; k < 4; k++) w[8*k +: 8] = 8'((a + k) % 256) ^ 8'hA5;
        return w;
    endfunction

    function automatic logic [31:0] msk(input logic [3:0] v);
        logic [31:0] m;
        for (int k = 0; k < 4; k++) m[8*k +: 8] = {8{v[k]}};
        return m;
    endfunction

    // Reference model: memory image with per-lane known bits, and a count of edges since Start.
    logic [31:0] m_mem [D];
    logic [3:0]  m_lv  [D];
    logic [31:0] m_rd;
    logic [3:0]  m_rv;
    int          m_bk;
    logic        m_done;
    int          m_err;

    initial begin
        for (int i = 0; i < D; i++) begin
            m_mem[i] = '0;
            m_lv[i]  = '0;
        end
        m_rd = '0; m_rv = '0; m_bk = 0; m_done = 1'b0; m_err = 0;
    end

    always @(posedge clk) begin : model
        logic [31:0] prev;
        int a;
        prev = m_rd;
        if (rst) begin
            m_bk = 0; m_done = 1'b0; m_err = 0; m_rd = '0; m_rv = 4'hF;
        end else if (m_bk == 0) begin
            m_rd = m_mem[mem_addr];
            m_rv = m_lv[mem_addr];
            if (start) begin
                m_bk = 1; m_done = 1'b0; m_err = 0;
            end else if (mem_write) begin
                for (int k = 0; k < 4; k++) begin
                    if (byte_en[k]) begin
                        m_mem[mem_addr][8*k +: 8] = w_data[8*k +: 8];
                        m_lv[mem_addr][k] = 1'b1;
                    end
                end
            end
        end else begin
            if (m_bk <= D) begin
                a = m_bk - 1;
                m_mem[a] = pat(a) ^ {31'b0, fault};
                m_lv[a]  = 4'hF;
                m_rv     = 4'h0;
            end else if (m_bk <= 2*D) begin
                a = m_bk - D - 1;
                m_rd = m_mem[a];
                m_rv = 4'hF;
            end else begin
                m_rv = 4'h0;
            end
            if (m_bk >= D + 2) begin
                a = m_bk - D - 2;
                if (prev != pat(a) && m_err < 127) m_err++;
            end
            if (m_bk == 2*D + 1) begin
                m_bk = 0; m_done = 1'b1;
            end else begin
                m_bk++;
            end
        end
    end

    bit chk_on = 1'b0;

    // Every-cycle comparison of the main DUT against the model.
    always @(negedge clk) begin
        if (chk_on) begin
            chk("busy", 32'(busy), 32'(m_bk != 0));
            chk("done", 32'(done), 32'(m_done));
            chk("pass", 32'(pass), 32'(m_done && m_err == 0));
            chk("err_count", 32'(err_count), 32'(m_err));
            if (m_rv != 4'h0) chk("rd_data", rd_data & msk(m_rv), m_rd & msk(m_rv));
            if (m_rv[sel]) chk("led", 32'(led), 32'(m_rd[8*int'(sel) +: 8]));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic mwrite(input logic [5:0] a, input logic [31:0] d, input logic [3:0] be);
        mem_addr = a; w_data = d; byte_en = be; mem_write = 1'b1;
        cyc();
        mem_write = 1'b0;
    endtask

    // Pulse Start, count Busy cycles until Done; optionally pulse Start again mid-READ.
    task automatic run_bist(input bit start_mid, output int busy_n);
        start = 1'b1;
        cyc();
        start = 1'b0;
        mem_write = 1'b0;
        busy_n = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (done) break;
            if (busy) busy_n++;
            start = (start_mid && busy_n == 100);
        end
        start = 1'b0;
        chk("bist_completes", 32'(done), 32'd1);
    endtask

    int n;

    initial begin
        rst = 1'b1; start = 1'b0; fault = 1'b0; mem_write = 1'b0;
        mem_addr = '0; byte_en = '0; w_data = '0; sel = '0;
        a_start = 1'b0; a_fault = 1'b0; a_mem_write = 1'b0;
        a_mem_addr = '0; a_byte_en = '0; a_w_data = '0; a_sel = '0;
        cyc();
        chk_on = 1'b1;
        cyc();
        rst = 1'b0;
        @(negedge clk);
        chk("reset_rd", rd_data, 32'h0);
        chk("reset_led", 32'(led), 32'h0);
        chk("reset_flags", {29'b0, busy, done, pass}, 32'h0);

        // Manual lane-masked write.
        mwrite(6'd3, 32'h0, 4'hF);
        mwrite(6'd3, 32'h11223344, 4'b0101);
        cyc();
        @(negedge clk);
        chk("manual_be", rd_data, 32'h00220044);
        sel = 2'd1;
        @(negedge clk);
        chk("led_sel1", 32'(led), 32'h00);
        sel = 2'd2;
        @(negedge clk);
        chk("led_sel2", 32'(led), 32'h22);

        // Byte_En == 0 write leaves the word alone.
        mwrite(6'd3, 32'hFFFFFFFF, 4'h0);
        cyc();
        @(negedge clk);
        chk("be_zero_noop", rd_data, 32'h00220044);

        // Read-during-write shows old contents.
        mwrite(6'd5, 32'hDEADBEEF, 4'hF);
        mwrite(6'd5, 32'h01020304, 4'hF);
        @(negedge clk);
        chk("read_first_old", rd_data, 32'hDEADBEEF);
        cyc();
        @(negedge clk);
        chk("read_first_new", rd_data, 32'h01020304);

        // Clean BIST.
        run_bist(1'b0, n);
        chk("clean_busy_cycles", 32'(n), 32'd129);
        chk("clean_pass", 32'(pass), 32'd1);
        chk("clean_err", 32'(err_count), 32'd0);
        mem_addr = 6'd2;
        cyc();
        @(negedge clk);
        chk("addr2_pattern", rd_data, 32'hA0A1A6A7);

        // Start with Mem_Write in DONE, plus Start during READ.
        mem_addr = 6'd7; w_data = 32'hFFFFFFFF; byte_en = 4'hF; mem_write = 1'b1;
        run_bist(1'b1, n);
        chk("collide_busy_cycles", 32'(n), 32'd129);
        chk("collide_pass", 32'(pass), 32'd1);

        // Fault-injected BIST.
        fault = 1'b1;
        run_bist(1'b0, n);
        fault = 1'b0;
        chk("fault_err", 32'(err_count), 32'd64);
        chk("fault_pass", 32'(pass), 32'd0);

        // Reset mid-write: ten words rewritten cleanly, the rest keep the faulted image.
        start = 1'b1;
        cyc();
        start = 1'b0;
        repeat (10) cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_flags", {29'b0, busy, done, pass}, 32'h0);
        chk("midrst_err", 32'(err_count), 32'h0);
        chk("midrst_rd", rd_data, 32'h0);
        mem_addr = 6'd0;
        cyc();
        @(negedge clk);
        chk("midrst_addr0", rd_data, 32'hA6A7A4A5);
        mem_addr = 6'd9;
        cyc();
        @(negedge clk);
        chk("midrst_addr9", rd_data, 32'hA9AEAFAC);
        mem_addr = 6'd12;
        cyc();
        @(negedge clk);
        chk("midrst_addr12", rd_data, 32'hAAABA8A8);

        // Random traffic checked by the model every cycle.
        for (int i = 0; i < 1500; i++) begin
            mem_addr  = 6'($urandom);
            mem_write = 1'($urandom_range(0, 1));
            byte_en   = 4'($urandom);
            w_data    = $urandom;
            sel       = 2'($urandom);
            start     = ($urandom_range(0, 59) == 0);
            fault     = ($urandom_range(0, 3) == 0);
            rst       = ($urandom_range(0, 499) == 0);
            cyc();
        end
        start = 1'b0; mem_write = 1'b0; fault = 1'b0; rst = 1'b0;
        repeat (140) cyc();

        // Narrow configuration: 16-bit words, 16 entries.
        a_start = 1'b1;
        cyc();
        a_start = 1'b0;
        n = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (a_done) break;
            if (a_busy) n++;
        end
        chk("alt_done", 32'(a_done), 32'd1);
        chk("alt_busy_cycles", 32'(n), 32'd33);
        chk("alt_pass", 32'(a_pass), 32'd1);
        a_mem_addr = 4'd3;
        cyc();
        @(negedge clk);
        chk("alt_addr3_pattern", 32'(a_rd), 32'h0000A1A6);
        a_w_data = 16'hBEEF; a_byte_en = 2'b11; a_mem_write = 1'b1;
        cyc();
        a_mem_write = 1'b0;
        cyc();
        a_sel = 1'b1;
        @(negedge clk);
        chk("alt_led_hi", 32'(a_led), 32'hBE);
        a_sel = 1'b0;
        @(negedge clk);
        chk("alt_led_lo", 32'(a_led), 32'hEF);

        chk_on = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
